// File: rtl/apb_exe_queue_ctrl.sv
// APB register front-end for an execution unit: operand registers, a command FIFO
// feeding the unit and a result FIFO drained by APB reads, all with one wait state.
module apb_exe_queue_ctrl #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16,
    parameter int CMD_DEPTH  = 4,
    parameter int RES_DEPTH  = 4
) (
    input  logic                  i_PCLK,
    input  logic                  i_PRESETn,
    input  logic [ADDR_WIDTH-1:0] i_PADDR,
    input  logic                  i_PSEL,
    input  logic                  i_PENABLE,
    input  logic                  i_PWRITE,
    input  logic [DATA_WIDTH-1:0] i_PWDATA,
    output logic                  o_PREADY,
    output logic [DATA_WIDTH-1:0] o_PRDATA,
    output logic                  o_PSLVERR,
    output logic [DATA_WIDTH-1:0] o_EXE_OPER,
    output logic [DATA_WIDTH-1:0] o_EXE_ARGA,
    output logic [DATA_WIDTH-1:0] o_EXE_ARGB,
    output logic                  o_EXE_VALID,
    input  logic                  i_EXE_READY,
    input  logic                  i_RES_VALID,
    input  logic [DATA_WIDTH-1:0] i_RES_DATA,
    input  logic [3:0]            i_RES_STATUS
);

    localparam int CPW = $clog2(CMD_DEPTH);
    localparam int RPW = $clog2(RES_DEPTH);
    localparam int CW  = 3 * DATA_WIDTH;
    localparam int RW  = DATA_WIDTH + 4;

    logic [DATA_WIDTH-1:0] oper_q, arga_q, argb_q;
    logic [3:0]            last_status;
    logic                  ovf;

    logic [CW-1:0]  cmd_mem [CMD_DEPTH];
    logic [CPW-1:0] cmd_wr_ptr, cmd_rd_ptr;
    logic [CPW:0]   cmd_cnt;
    logic [RW-1:0]  res_mem [RES_DEPTH];
    logic [RPW-1:0] res_wr_ptr, res_rd_ptr;
    logic [RPW:0]   res_cnt;

    logic access;
    logic sel_oper, sel_arga, sel_argb, sel_cmd, sel_result, sel_status;
    logic cmd_full, cmd_empty, res_full, res_empty;
    logic cmd_push, cmd_pop, res_push, res_pop, res_ovf, status_rd;
    logic [CW-1:0] cmd_head;
    logic [RW-1:0] res_head;
    logic [DATA_WIDTH-1:0] rsp_data;
    logic rsp_err;

    function automatic logic [DATA_WIDTH-1:0] pack_status(
        input logic c_full, input logic c_empty, input logic r_full, input logic r_empty,
        input logic [3:0] last, input logic overflow);
        logic [DATA_WIDTH-1:0] s;
        s      = '0;
        s[0]   = c_full;
        s[1]   = c_empty;
        s[2]   = r_full;
        s[3]   = r_empty;
        s[7:4] = last;
        s[8]   = overflow;
        return s;
    endfunction

    // The action cycle is the first PSEL&PENABLE cycle; PREADY high marks completion.
    assign access     = i_PSEL & i_PENABLE & ~o_PREADY;
    assign sel_oper   = (i_PADDR == ADDR_WIDTH'(0));
    assign sel_arga   = (i_PADDR == ADDR_WIDTH'(1));
    assign sel_argb   = (i_PADDR == ADDR_WIDTH'(2));
    assign sel_cmd    = (i_PADDR == ADDR_WIDTH'(3));
    assign sel_result = (i_PADDR == ADDR_WIDTH'(4));
    assign sel_status = (i_PADDR == ADDR_WIDTH'(5));

    assign cmd_full  = (cmd_cnt == (CPW+1)'(CMD_DEPTH));
    assign cmd_empty = (cmd_cnt == '0);
    assign res_full  = (res_cnt == (RPW+1)'(RES_DEPTH));
    assign res_empty = (res_cnt == '0);

    assign cmd_head    = cmd_mem[cmd_rd_ptr];
    assign res_head    = res_mem[res_rd_ptr];
    assign o_EXE_VALID = ~cmd_empty;
    assign o_EXE_OPER  = cmd_head[CW-1 -: DATA_WIDTH];
    assign o_EXE_ARGA  = cmd_head[2*DATA_WIDTH-1 -: DATA_WIDTH];
    assign o_EXE_ARGB  = cmd_head[DATA_WIDTH-1:0];

    // A full FIFO still accepts when its head leaves in the same cycle.
    assign cmd_pop   = o_EXE_VALID & i_EXE_READY;
    assign cmd_push  = access & i_PWRITE & sel_cmd & (~cmd_full | cmd_pop);
    assign res_pop   = access & ~i_PWRITE & sel_result & ~res_empty;
    assign res_push  = i_RES_VALID & (~res_full | res_pop);
    assign res_ovf   = i_RES_VALID & res_full & ~res_pop;
    assign status_rd = access & ~i_PWRITE & sel_status;

    always_comb begin
        rsp_data = '0;
        rsp_err  = 1'b0;
        if (i_PWRITE) begin
            if (sel_oper || sel_arga || sel_argb) begin
                rsp_err = 1'b0;
            end else if (sel_cmd) begin
                rsp_err = cmd_full & ~cmd_pop;
            end else begin
                rsp_err = 1'b1;
            end
        end else begin
            if (sel_oper) begin
                rsp_data = oper_q;
            end else if (sel_arga) begin
                rsp_data = arga_q;
            end else if (sel_argb) begin
                rsp_data = argb_q;
            end else if (sel_result) begin
                if (res_empty) rsp_err = 1'b1;
                else           rsp_data = res_head[RW-1 -: DATA_WIDTH];
            end else if (sel_status) begin
                rsp_data = pack_status(cmd_full, cmd_empty, res_full, res_empty, last_status, ovf);
            end else begin
                rsp_err = 1'b1;
            end
        end
    end

    always_ff @(posedge i_PCLK or negedge i_PRESETn) begin
        if (!i_PRESETn) begin
            o_PREADY  <= 1'b0;
            o_PRDATA  <= '0;
            o_PSLVERR <= 1'b0;
        end else if (access) begin
            o_PREADY  <= 1'b1;
            o_PRDATA  <= rsp_data;
            o_PSLVERR <= rsp_err;
        end else begin
            o_PREADY  <= 1'b0;
            o_PRDATA  <= '0;
            o_PSLVERR <= 1'b0;
        end
    end

    always_ff @(posedge i_PCLK or negedge i_PRESETn) begin
        if (!i_PRESETn) begin
            oper_q      <= '0;
            arga_q      <= '0;
            argb_q      <= '0;
            last_status <= '0;
            ovf         <= 1'b0;
        end else begin
            if (access && i_PWRITE && sel_oper) oper_q <= i_PWDATA;
            if (access && i_PWRITE && sel_arga) arga_q <= i_PWDATA;
            if (access && i_PWRITE && sel_argb) argb_q <= i_PWDATA;
            if (res_pop) last_status <= res_head[3:0];
            // A drop in the same cycle as a STATUS read must survive the clear.
            ovf <= res_ovf | (ovf & ~status_rd);
        end
    end

    always_ff @(posedge i_PCLK or negedge i_PRESETn) begin
        if (!i_PRESETn) begin
            cmd_wr_ptr <= '0;
            cmd_rd_ptr <= '0;
            cmd_cnt    <= '0;
            res_wr_ptr <= '0;
            res_rd_ptr <= '0;
            res_cnt    <= '0;
        end else begin
            if (cmd_push) cmd_wr_ptr <= cmd_wr_ptr + 1'b1;
            if (cmd_pop)  cmd_rd_ptr <= cmd_rd_ptr + 1'b1;
            case ({cmd_push, cmd_pop})
                2'b10:   cmd_cnt <= cmd_cnt + 1'b1;
                2'b01:   cmd_cnt <= cmd_cnt - 1'b1;
                default: cmd_cnt <= cmd_cnt;
            endcase
            if (res_push) res_wr_ptr <= res_wr_ptr + 1'b1;
            if (res_pop)  res_rd_ptr <= res_rd_ptr + 1'b1;
            case ({res_push, res_pop})
                2'b10:   res_cnt <= res_cnt + 1'b1;
                2'b01:   res_cnt <= res_cnt - 1'b1;
                default: res_cnt <= res_cnt;
            endcase
        end
    end

    // Storage arrays hold data only; validity lives in the counts.
    always_ff @(posedge i_PCLK) begin
        if (cmd_push) cmd_mem[cmd_wr_ptr] <= {oper_q, arga_q, argb_q};
        if (res_push) res_mem[res_wr_ptr] <= {i_RES_DATA, i_RES_STATUS};
    end

endmodule

// File: tb/tb_apb_exe_queue_ctrl.sv
// Bench for apb_exe_queue_ctrl: table of register transfers plus hand sequences
// for FIFO full/empty, overflow and mid-transfer reset, scoreboarded via queues.
module tb_apb_exe_queue_ctrl;

    localparam int DW = 16;
    localparam int AW = 16;
    localparam int CD = 4;
    localparam int RD = 4;

    logic          clk = 1'b0;
    logic          rstn;
    logic [AW-1:0] paddr;
    logic          psel, penable, pwrite;
    logic [DW-1:0] pwdata;
    logic          pready;
    logic [DW-1:0] prdata;
    logic          pslverr;
    logic [DW-1:0] exe_oper, exe_arga, exe_argb;
    logic          exe_valid, exe_ready;
    logic          res_valid;
    logic [DW-1:0] res_data;
    logic [3:0]    res_status;

    always #5 clk = ~clk;

    apb_exe_queue_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CMD_DEPTH(CD), .RES_DEPTH(RD)) dut (
        .i_PCLK(clk), .i_PRESETn(rstn),
        .i_PADDR(paddr), .i_PSEL(psel), .i_PENABLE(penable), .i_PWRITE(pwrite), .i_PWDATA(pwdata),
        .o_PREADY(pready), .o_PRDATA(prdata), .o_PSLVERR(pslverr),
        .o_EXE_OPER(exe_oper), .o_EXE_ARGA(exe_arga), .o_EXE_ARGB(exe_argb),
        .o_EXE_VALID(exe_valid), .i_EXE_READY(exe_ready),
        .i_RES_VALID(res_valid), .i_RES_DATA(res_data), .i_RES_STATUS(res_status)
    );

    int checks   = 0;
    int failures = 0;
    int exe_pops = 0;

    typedef struct {
        logic [DW-1:0] rd;
        logic          err;
        string         name;
    } rsp_t;

    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wd;
        logic [DW-1:0] rd;
        logic          err;
        string         name;
    } vec_t;

    rsp_t              rsp_q[$];
    logic [3*DW-1:0]   exe_q[$];
    logic [DW-1:0]     m_oper, m_arga, m_argb;
    vec_t              tbl[12];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
    task automatic apb(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                       input logic [DW-1:0] exp_rd, input logic exp_err, input string name,
                       input bit pulse_rdy);
        rsp_t r;
        int   waits;
        r.rd = exp_rd; r.err = exp_err; r.name = name;
        rsp_q.push_back(r);
        if (wr && !exp_err) begin
            case (addr)
                AW'(0):  m_oper = wd;
                AW'(1):  m_arga = wd;
                AW'(2):  m_argb = wd;
                AW'(3):  exe_q.push_back({m_oper, m_arga, m_argb});
                default: ;
            endcase
        end
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wd;
        @(posedge clk); #1;
        penable = 1'b1;
        if (pulse_rdy) exe_ready = 1'b1;
        waits = 0;
        @(negedge clk);
        while (!pready && waits < 8) begin
            waits++;
            if (pulse_rdy && waits == 1) begin
                @(posedge clk); #1;
                exe_ready = 1'b0;
            end
            @(negedge clk);
        end
        chk({name, ".waits"}, 64'(waits), 64'd1);
        r = rsp_q.pop_front();
        chk({r.name, ".prdata"}, 64'(prdata), 64'(r.rd));
        chk({r.name, ".pslverr"}, 64'(pslverr), 64'(r.err));
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        @(negedge clk);
        chk({name, ".idle"}, {46'd0, pready, pslverr, prdata}, 64'd0);
    endtask

    task automatic res_push(input logic [DW-1:0] d, input logic [3:0] s);
        @(posedge clk); #1;
        res_valid = 1'b1; res_data = d; res_status = s;
        @(posedge clk); #1;
        res_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rstn && exe_valid && exe_ready) begin
            exe_pops++;
            if (exe_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL exe_unexpected actual=0x%0h required=none", {exe_oper, exe_arga, exe_argb});
            end else begin
                chk("exe_head", 64'({exe_oper, exe_arga, exe_argb}), 64'(exe_q.pop_front()));
            end
        end
    end

    initial begin
        tbl[0]  = '{1'b1, AW'(0), 16'h0003, 16'h0000, 1'b0, "wr_oper"};
        tbl[1]  = '{1'b1, AW'(1), 16'h0010, 16'h0000, 1'b0, "wr_arga"};
        tbl[2]  = '{1'b1, AW'(2), 16'h0020, 16'h0000, 1'b0, "wr_argb"};
        tbl[3]  = '{1'b0, AW'(0), 16'h0000, 16'h0003, 1'b0, "rd_oper"};
        tbl[4]  = '{1'b0, AW'(1), 16'h0000, 16'h0010, 1'b0, "rd_arga"};
        tbl[5]  = '{1'b0, AW'(2), 16'h0000, 16'h0020, 1'b0, "rd_argb"};
        tbl[6]  = '{1'b0, AW'(7), 16'h0000, 16'h0000, 1'b1, "rd_idx7"};
        tbl[7]  = '{1'b1, AW'(5), 16'hFFFF, 16'h0000, 1'b1, "wr_status"};
        tbl[8]  = '{1'b1, AW'(4), 16'hFFFF, 16'h0000, 1'b1, "wr_result"};
        tbl[9]  = '{1'b0, AW'(3), 16'h0000, 16'h0000, 1'b1, "rd_cmd"};
        tbl[10] = '{1'b0, AW'(0), 16'h0000, 16'h0003, 1'b0, "rd_oper_kept"};
        tbl[11] = '{1'b0, AW'(5), 16'h0000, 16'h000A, 1'b0, "rd_status_idle"};

        rstn = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
        exe_ready = 1'b0; res_valid = 1'b0; res_data = '0; res_status = '0;
        m_oper = '0; m_arga = '0; m_argb = '0;
        repeat (3) @(negedge clk);
        chk("reset.outs", {45'd0, pready, pslverr, exe_valid, prdata}, 64'd0);
        @(posedge clk); #1;
        rstn = 1'b1;

        foreach (tbl[i])
            apb(tbl[i].wr, tbl[i].addr, tbl[i].wd, tbl[i].rd, tbl[i].err, tbl[i].name, 1'b0);

        // First command lands at the head with the operands written above.
        apb(1'b1, AW'(3), 16'hBEEF, 16'h0, 1'b0, "cmd0", 1'b0);
        chk("exe_valid.cmd0", 64'(exe_valid), 64'd1);
        chk("exe_fields.cmd0", 64'({exe_oper, exe_arga, exe_argb}), 64'h0003_0010_0020);

        for (int i = 1; i < CD; i++) begin
            apb(1'b1, AW'(0), DW'(16'h0040 + i), 16'h0, 1'b0, "wr_oper_q", 1'b0);
            apb(1'b1, AW'(3), 16'h0, 16'h0, 1'b0, "cmd_fill", 1'b0);
        end
        apb(1'b1, AW'(3), 16'h0, 16'h0, 1'b1, "cmd_overflow", 1'b0);
        apb(1'b0, AW'(5), 16'h0, 16'h0009, 1'b0, "status_cmd_full", 1'b0);

        // Push on a full FIFO while the unit pops in the action cycle.
        apb(1'b1, AW'(0), 16'h0077, 16'h0, 1'b0, "wr_oper_77", 1'b0);
        apb(1'b1, AW'(3), 16'h0, 16'h0, 1'b0, "cmd_full_pop", 1'b1);
        apb(1'b0, AW'(5), 16'h0, 16'h0009, 1'b0, "status_still_full", 1'b0);

        @(posedge clk); #1;
        exe_ready = 1'b1;
        for (int n = 0; n < 20 && exe_valid; n++) @(negedge clk);
        @(posedge clk); #1;
        exe_ready = 1'b0;
        chk("drain.queue_left", 64'(exe_q.size()), 64'd0);
        chk("drain.pops", 64'(exe_pops), 64'(CD + 1));
        apb(1'b0, AW'(5), 16'h0, 16'h000A, 1'b0, "status_drained", 1'b0);

        res_push(16'h1234, 4'hA);
        apb(1'b0, AW'(4), 16'h0, 16'h1234, 1'b0, "rd_result", 1'b0);
        apb(1'b0, AW'(5), 16'h0, 16'h00AA, 1'b0, "status_last_a", 1'b0);
        apb(1'b0, AW'(4), 16'h0, 16'h0000, 1'b1, "rd_result_empty", 1'b0);

        for (int i = 0; i <= RD; i++) begin
            @(posedge clk); #1;
            res_valid = 1'b1; res_data = DW'(16'h0100 + i); res_status = 4'(i);
        end
        @(posedge clk); #1;
        res_valid = 1'b0;
        apb(1'b0, AW'(5), 16'h0, 16'h01A6, 1'b0, "status_ovf_set", 1'b0);
        apb(1'b0, AW'(5), 16'h0, 16'h00A6, 1'b0, "status_ovf_clr", 1'b0);
        for (int i = 0; i < RD; i++)
            apb(1'b0, AW'(4), 16'h0, DW'(16'h0100 + i), 1'b0, "rd_result_seq", 1'b0);
        apb(1'b0, AW'(5), 16'h0, 16'h003A, 1'b0, "status_last_3", 1'b0);

        // Reset during the PREADY cycle of a transfer with two commands queued.
        apb(1'b1, AW'(3), 16'h0, 16'h0, 1'b0, "cmd_pre_rst_a", 1'b0);
        apb(1'b1, AW'(3), 16'h0, 16'h0, 1'b0, "cmd_pre_rst_b", 1'b0);
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = AW'(0); pwdata = 16'h0055;
        @(posedge clk); #1;
        penable = 1'b1;
        @(posedge clk); #1;
        rstn = 1'b0;
        #1;
        chk("rst_mid.outs", {45'd0, pready, pslverr, exe_valid, prdata}, 64'd0);
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        exe_q.delete();
        m_oper = '0; m_arga = '0; m_argb = '0;
        @(negedge clk);
        rstn = 1'b1;
        apb(1'b0, AW'(5), 16'h0, 16'h000A, 1'b0, "status_after_rst", 1'b0);
        apb(1'b0, AW'(0), 16'h0, 16'h0000, 1'b0, "oper_after_rst", 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/apb_exe_queue_ctrl.md
APB_EXE_QUEUE_CTRL -- requirements
Module: apb_exe_queue_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, APB data width and execution-unit operand/result width; legal values 16..32.
REQ-002 SHALL have parameter ADDR_WIDTH, default 16, APB address width.
REQ-003 SHALL have parameter CMD_DEPTH, default 4, command FIFO entries; power of two, 2..16.
REQ-004 SHALL have parameter RES_DEPTH, default 4, result FIFO entries; power of two, 2..16.
REQ-005 SHALL have port i_PCLK  in  1  clock; all logic on its rising edge.
REQ-006 SHALL have port i_PRESETn  in  1  reset; asynchronous, active-low.
REQ-007 SHALL have APB inputs i_PADDR[ADDR_WIDTH], i_PSEL, i_PENABLE, i_PWRITE and i_PWDATA[DATA_WIDTH], each with APB meaning.
REQ-008 SHALL have APB outputs o_PREADY (1), o_PRDATA[DATA_WIDTH] and o_PSLVERR (1).
REQ-009 SHALL have execution-unit command outputs o_EXE_OPER, o_EXE_ARGA and o_EXE_ARGB (each DATA_WIDTH), plus o_EXE_VALID (1); input i_EXE_READY (1).
REQ-010 SHALL have execution-unit result inputs i_RES_VALID (1), i_RES_DATA[DATA_WIDTH] and i_RES_STATUS[4].

Function
REQ-011 SHALL decode register index = i_PADDR; 0 OPER RW, 1 ARGA RW, 2 ARGB RW, 3 CMD WO, 4 RESULT RO, 5 STATUS RO; any other index is invalid.
REQ-012 SHALL give every transfer exactly one wait state: first cycle with PSEL&PENABLE&!PREADY performs the action and registers PREADY=1 with PRDATA/PSLVERR; next cycle PREADY=1 completes it; PREADY returns to 0 the cycle after.
REQ-013 SHALL perform each register side effect (write, push, pop, clear) exactly once per transfer, in the action cycle only.
REQ-014 SHALL drive o_PRDATA=0 for writes, errored transfers and idle cycles; o_PSLVERR only alongside o_PREADY.
REQ-015 SHALL let a CMD write (data ignored) push {OPER,ARGA,ARGB} into the command FIFO; if the FIFO is full and not popping that cycle -> no push, PSLVERR=1.
REQ-016 SHALL drive o_EXE_VALID = command FIFO not empty, with o_EXE_* = head entry; pop when o_EXE_VALID&i_EXE_READY.
REQ-017 SHALL accept a push on a full command FIFO if the exe pop happens in the same cycle.
REQ-018 SHALL push {i_RES_DATA,i_RES_STATUS} into the result FIFO when i_RES_VALID=1; if full and not popped that cycle -> entry dropped, sticky OVF set.
REQ-019 SHALL have a RESULT read return the head result data and pop it, latching its status into LAST_STATUS; on empty -> PRDATA=0, PSLVERR=1, no pop.
REQ-020 SHALL define STATUS as: [0] cmd_full, [1] cmd_empty, [2] res_full, [3] res_empty, [7:4] LAST_STATUS, [8] OVF, upper bits 0.
REQ-021 SHALL have a STATUS read clear OVF after sampling; an overflow in the same cycle keeps OVF=1.
REQ-022 SHALL answer writes to RESULT/STATUS, reads of CMD and invalid indices with PSLVERR=1 and no state change.
REQ-023 SHALL have reads of OPER/ARGA/ARGB return the stored value with PSLVERR=0.
REQ-024 SHALL keep FIFO pointers wrapping modulo depth, with a separate count deciding full/empty.
REQ-025 SHALL ignore PENABLE without PSEL, and keep PREADY low.

Reset
REQ-026 SHALL, while i_PRESETn=0, asynchronously clear o_PREADY, o_PRDATA, o_PSLVERR, o_EXE_VALID, OPER, ARGA, ARGB, LAST_STATUS, OVF and both FIFO counts/pointers to 0.
REQ-027 SHALL, on reset asserted mid-transfer or mid-queue, discard all pending entries; after release, resume with idle APB.

Verification
REQ-028 SHALL cover: write OPER=3, ARGA=0x10, ARGB=0x20, CMD -> each transfer is 2 access cycles with PSLVERR=0; o_EXE_VALID=1 with 3/0x10/0x20.
REQ-029 SHALL cover: i_EXE_READY=0 with CMD_DEPTH+1 CMD writes -> last write PSLVERR=1; STATUS[0]=1; READY=1 then drains 4 entries in order.
REQ-030 SHALL cover: i_RES_VALID with data 0x1234, status 0xA, then RESULT read -> PRDATA=0x1234; STATUS[7:4]=0xA, [3]=1.
REQ-031 SHALL cover: RESULT read on empty -> PRDATA=0, PSLVERR=1; RES_DEPTH+1 results pushed -> STATUS[8]=1 on first read, 0 on second.
REQ-032 SHALL cover: read index 7 and write index 5 -> PSLVERR=1, registers unchanged; full cmd FIFO with CMD write and exe pop in same cycle -> accepted, count unchanged.
REQ-033 SHALL cover: PRESETn low during the wait-state cycle with 2 queued commands -> PREADY=0, o_EXE_VALID=0 immediately, STATUS=0x000A after release.
